// File: rtl/watch_time_keeper.sv
// ============================================================================
// Module   : watch_time_keeper
// Brief    : BCD time-of-day keeper with loadable time, prescaled seconds
//            and an optional 12 h mode (define WATCH_12H_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module watch_time_keeper #(
    parameter int TICKS_PER_SEC = 1000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  logic [3:0] set_h1,
    input  logic [3:0] set_h0,
    input  logic [3:0] set_m1,
    input  logic [3:0] set_m0,
    input  logic       run,
`ifdef WATCH_12H_EN
    input  logic       set_pm,
    output logic       pm,
`endif
    output logic [3:0] h1,
    output logic [3:0] h0,
    output logic [3:0] m1,
    output logic [3:0] m0,
    output logic [3:0] s1,
    output logic [3:0] s0,
    output logic       sec_tick,
    output logic       hour_pulse,
    output logic       load_err
);

    localparam logic [15:0] c_PRE_LAST = 16'(TICKS_PER_SEC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_TICK  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pre_q, pre_d;
    logic [3:0]  h1_q, h0_q, m1_q, m0_q, s1_q, s0_q;
    logic [3:0]  h1_d, h0_d, m1_d, m0_d, s1_d, s0_d;
    logic        sec_tick_q, sec_tick_d;
    logic        hour_pulse_q, hour_pulse_d;
    logic        load_err_q, load_err_d;
`ifdef WATCH_12H_EN
    logic        pm_q, pm_d, inc_pm;
`endif

    logic [3:0]  inc_h1, inc_h0, inc_m1, inc_m0, inc_s1, inc_s0;
    logic        w_hour_roll, w_tc, w_legal, w_hours_ok;

    assign w_tc = run && (pre_q == c_PRE_LAST);

`ifdef WATCH_12H_EN
    assign w_hours_ok = ((set_h1 == 4'd0) && (set_h0 != 4'd0)) ||
                        ((set_h1 == 4'd1) && (set_h0 <= 4'd2));
`else
    assign w_hours_ok = (set_h1 < 4'd2) ||
                        ((set_h1 == 4'd2) && (set_h0 <= 4'd3));
`endif

    assign w_legal = w_hours_ok && (set_h0 <= 4'd9) &&
                     (set_m1 <= 4'd5) && (set_m0 <= 4'd9);

    // One-second increment of the current time, rippling carries upward.
    always_comb begin
        inc_h1      = h1_q;
        inc_h0      = h0_q;
        inc_m1      = m1_q;
        inc_m0      = m0_q;
        inc_s1      = s1_q;
        inc_s0      = s0_q;
        w_hour_roll = 1'b0;
`ifdef WATCH_12H_EN
        inc_pm      = pm_q;
`endif
        if (s0_q != 4'd9) begin
            inc_s0 = s0_q + 4'd1;
        end else begin
            inc_s0 = 4'd0;
            if (s1_q != 4'd5) begin
                inc_s1 = s1_q + 4'd1;
            end else begin
                inc_s1 = 4'd0;
                if (m0_q != 4'd9) begin
                    inc_m0 = m0_q + 4'd1;
                end else begin
                    inc_m0 = 4'd0;
                    if (m1_q != 4'd5) begin
                        inc_m1 = m1_q + 4'd1;
                    end else begin
                        inc_m1      = 4'd0;
                        w_hour_roll = 1'b1;
`ifdef WATCH_12H_EN
                        if ((h1_q == 4'd1) && (h0_q == 4'd2)) begin
                            inc_h1 = 4'd0;
                            inc_h0 = 4'd1;
                        end else if ((h1_q == 4'd1) && (h0_q == 4'd1)) begin
                            inc_h0 = 4'd2;
                            inc_pm = ~pm_q;
                        end else if (h0_q == 4'd9) begin
                            inc_h1 = 4'd1;
                            inc_h0 = 4'd0;
                        end else begin
                            inc_h0 = h0_q + 4'd1;
                        end
`else
                        if ((h1_q == 4'd2) && (h0_q == 4'd3)) begin
                            inc_h1 = 4'd0;
                            inc_h0 = 4'd0;
                        end else if (h0_q == 4'd9) begin
                            inc_h1 = h1_q + 4'd1;
                            inc_h0 = 4'd0;
                        end else begin
                            inc_h0 = h0_q + 4'd1;
                        end
`endif
                    end
                end
            end
        end
    end

    // Load beats the increment; an illegal load freezes time and prescaler.
    always_comb begin
        state_d      = state_q;
        pre_d        = pre_q;
        h1_d         = h1_q;
        h0_d         = h0_q;
        m1_d         = m1_q;
        m0_d         = m0_q;
        s1_d         = s1_q;
        s0_d         = s0_q;
        sec_tick_d   = 1'b0;
        hour_pulse_d = 1'b0;
        load_err_d   = 1'b0;
`ifdef WATCH_12H_EN
        pm_d         = pm_q;
`endif
        if (load && w_legal) begin
            h1_d    = set_h1;
            h0_d    = set_h0;
            m1_d    = set_m1;
            m0_d    = set_m0;
            s1_d    = 4'd0;
            s0_d    = 4'd0;
            pre_d   = 16'd0;
            state_d = run ? S_COUNT : S_IDLE;
`ifdef WATCH_12H_EN
            pm_d    = set_pm;
`endif
        end else if (load) begin
            load_err_d = 1'b1;
        end else begin
            if (run) begin
                pre_d = w_tc ? 16'd0 : pre_q + 16'd1;
            end
            if (w_tc) begin
                h1_d         = inc_h1;
                h0_d         = inc_h0;
                m1_d         = inc_m1;
                m0_d         = inc_m0;
                s1_d         = inc_s1;
                s0_d         = inc_s0;
                sec_tick_d   = 1'b1;
                hour_pulse_d = w_hour_roll;
`ifdef WATCH_12H_EN
                pm_d         = inc_pm;
`endif
            end
            case (state_q)
                S_IDLE:  state_d = run ? S_COUNT : S_IDLE;
                S_COUNT: state_d = w_tc ? S_TICK : (run ? S_COUNT : S_IDLE);
                S_TICK:  state_d = run ? S_COUNT : S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            pre_q        <= 16'd0;
`ifdef WATCH_12H_EN
            h1_q         <= 4'd1;
            h0_q         <= 4'd2;
            pm_q         <= 1'b0;
`else
            h1_q         <= 4'd0;
            h0_q         <= 4'd0;
`endif
            m1_q         <= 4'd0;
            m0_q         <= 4'd0;
            s1_q         <= 4'd0;
            s0_q         <= 4'd0;
            sec_tick_q   <= 1'b0;
            hour_pulse_q <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pre_q        <= pre_d;
            h1_q         <= h1_d;
            h0_q         <= h0_d;
            m1_q         <= m1_d;
            m0_q         <= m0_d;
            s1_q         <= s1_d;
            s0_q         <= s0_d;
            sec_tick_q   <= sec_tick_d;
            hour_pulse_q <= hour_pulse_d;
            load_err_q   <= load_err_d;
`ifdef WATCH_12H_EN
            pm_q         <= pm_d;
`endif
        end
    end

    assign h1         = h1_q;
    assign h0         = h0_q;
    assign m1         = m1_q;
    assign m0         = m0_q;
    assign s1         = s1_q;
    assign s0         = s0_q;
    assign sec_tick   = sec_tick_q;
    assign hour_pulse = hour_pulse_q;
    assign load_err   = load_err_q;
`ifdef WATCH_12H_EN
    assign pm         = pm_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_watch_time_keeper.sv
// ============================================================================
// Module   : tb_watch_time_keeper
// Brief    : Scoreboard bench for watch_time_keeper (24 h build, 4 ticks/s).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_watch_time_keeper;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       load = 1'b0;
    logic       run = 1'b0;
    logic [3:0] set_h1 = 4'd0, set_h0 = 4'd0, set_m1 = 4'd0, set_m0 = 4'd0;
    logic [3:0] h1, h0, m1, m0, s1, s0;
    logic       sec_tick, hour_pulse, load_err;
`ifdef WATCH_12H_EN
    logic       set_pm = 1'b0;
    logic       pm;
`endif

    watch_time_keeper #(.TICKS_PER_SEC(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (load),
        .set_h1     (set_h1),
        .set_h0     (set_h0),
        .set_m1     (set_m1),
        .set_m0     (set_m0),
        .run        (run),
`ifdef WATCH_12H_EN
        .set_pm     (set_pm),
        .pm         (pm),
`endif
        .h1         (h1),
        .h0         (h0),
        .m1         (m1),
        .m0         (m0),
        .s1         (s1),
        .s0         (s0),
        .sec_tick   (sec_tick),
        .hour_pulse (hour_pulse),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [23:0] tm;
        logic        tk;
        logic        hp;
        logic        er;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   pcnt = 0;
    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 1'b0;

    always @(posedge clk) pcnt <= pcnt + 1;

    function automatic logic [23:0] tm(input int hh, input int mm, input int ss);
        return {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10),
                4'(ss / 10), 4'(ss % 10)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, pcnt, act, req);
        end
    endtask

    // Monitor: pops the expectation due this cycle, otherwise requires silence.
    always @(negedge clk) begin
        if (mon_en) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < pcnt) begin
                checks++;
                failures++;
                $display("FAIL missed_event: expected at cycle %0d, now %0d", exp_q[0].cyc, pcnt);
                void'(exp_q.pop_front());
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == pcnt) begin
                mon_e = exp_q.pop_front();
                chk("time", {8'h0, h1, h0, m1, m0, s1, s0}, {8'h0, mon_e.tm});
                chk("sec_tick", {31'b0, sec_tick}, {31'b0, mon_e.tk});
                chk("hour_pulse", {31'b0, hour_pulse}, {31'b0, mon_e.hp});
                chk("load_err", {31'b0, load_err}, {31'b0, mon_e.er});
            end else begin
                chk("no_pulse", {29'b0, sec_tick, hour_pulse, load_err}, 32'd0);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (pcnt < c) step(1);
    endtask

    task automatic push(input int c, input logic [23:0] t, input logic tk,
                        input logic hp, input logic er);
        exp_t e;
        e.cyc = c; e.tm = t; e.tk = tk; e.hp = hp; e.er = er;
        exp_q.push_back(e);
    endtask

    // Drives a one-cycle load; returns the cycle in which its effect is visible.
    task automatic do_load(input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] c, input logic [3:0] d, output int vis);
        set_h1 = a; set_h0 = b; set_m1 = c; set_m0 = d;
        load   = 1'b1;
        vis    = pcnt + 1;
        step(1);
        load   = 1'b0;
    endtask

    task automatic run_minute(input int hh, input int mm, input logic [23:0] fin);
        int l;
        do_load(4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10), l);
        push(l, tm(hh, mm, 0), 1'b0, 1'b0, 1'b0);
        for (int k = 1; k < 60; k++) push(l + 4 * k, tm(hh, mm, k), 1'b1, 1'b0, 1'b0);
        push(l + 240, fin, 1'b1, 1'b1, 1'b0);
        wait_until(l + 240);
    endtask

    initial begin
        int l, q, r, t0;
        step(2);
        push(pcnt, 24'h000000, 1'b0, 1'b0, 1'b0);
        mon_en  = 1'b1;
        reset_n = 1'b1;
        step(1);

        // 12:34 with run high: tick every 4 cycles.
        run = 1'b1;
        do_load(4'd1, 4'd2, 4'd3, 4'd4, l);
        push(l, 24'h123400, 1'b0, 1'b0, 1'b0);
        push(l + 4, 24'h123401, 1'b1, 1'b0, 1'b0);
        push(l + 8, 24'h123402, 1'b1, 1'b0, 1'b0);
        wait_until(l + 8);

        run_minute(23, 59, 24'h000000);
        run_minute(9, 59, 24'h100000);

        // Advance pre to 2, then stop and try three illegal loads.
        step(2);
        run = 1'b0;
        do_load(4'd2, 4'd4, 4'd0, 4'd0, l);
        push(l, 24'h100000, 1'b0, 1'b0, 1'b1);
        do_load(4'd1, 4'd2, 4'd6, 4'd0, l);
        push(l, 24'h100000, 1'b0, 1'b0, 1'b1);
        do_load(4'd1, 4'hA, 4'd0, 4'd0, l);
        push(l, 24'h100000, 1'b0, 1'b0, 1'b1);
        step(2);
        push(pcnt, 24'h100000, 1'b0, 1'b0, 1'b0);
        q   = pcnt;
        run = 1'b1;
        push(q + 2, 24'h100001, 1'b1, 1'b0, 1'b0);
        wait_until(q + 3);

        // Pause for 10 cycles one count into a second.
        run = 1'b0;
        push(q + 8, 24'h100001, 1'b0, 1'b0, 1'b0);
        wait_until(q + 13);
        r   = pcnt;
        run = 1'b1;
        push(r + 3, 24'h100002, 1'b1, 1'b0, 1'b0);
        t0 = r + 3;

        // Load in the terminal-count cycle suppresses the tick.
        wait_until(t0 + 3);
        do_load(4'd1, 4'd2, 4'd0, 4'd0, l);
        push(l, 24'h120000, 1'b0, 1'b0, 1'b0);
        push(l + 4, 24'h120001, 1'b1, 1'b0, 1'b0);

        // Reset in a terminal-count cycle: no pulse, everything zero.
        wait_until(l + 7);
        reset_n = 1'b0;
        push(l + 8, 24'h000000, 1'b0, 1'b0, 1'b0);
        step(1);
        reset_n = 1'b1;
        push(l + 12, 24'h000001, 1'b1, 1'b0, 1'b0);
        wait_until(l + 13);
        run = 1'b0;
        step(3);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL leftover_expectations: got %0d pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
